priority_encoder_sync: RTL
==========================

Name: priority_encoder_sync

Overview:
- Parametrised, registered successor to the team's 8-to-3 one-hot encoder.
- Captures request bits from i[N-1:0] into a sticky pending register.
- Each cycle, picks one pending request by priority and presents its binary index on o with a valid/ready handshake.
- Sits between interrupt/request sources and a single downstream consumer. Multi-hot inputs are fully supported and no request is lost.

Parameters:
- N, 8, number of request lines; legal range 2..256.
- PRIO_LOW, 1, fixed-priority direction: 1 = lowest index wins, 0 = highest index wins.
- W, $clog2(N), localparam; width of o. Not user-settable.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous, active-low reset.
- en  input  1  request capture enable; when 0, i is ignored.
- i  input  N  request lines, level-sampled each clock.
- o_ready  input  1  consumer accepts o this cycle.
- o_valid  output  1  o holds a valid index.
- o  output  W  binary index of the granted request.
- o_multi  output  1  more than one request was candidate when o was loaded.
- pend  output  N  current pending-request register, for debug/status.

Behaviour:
- Reset (async assert, sync release): pend=0, o=0, o_valid=0, o_multi=0, RR pointer=0.
- cand = pend | (en ? i : 0), combinational.
- load = (!o_valid || o_ready), i.e. the output register is empty or is being consumed this cycle.
- When load is 1 and cand != 0:
  - idx = selected bit of cand.
  - o <= idx; o_valid <= 1; o_multi <= (popcount(cand) > 1).
  - pend <= cand & ~(1 << idx).
- When load is 1 and cand == 0: o_valid <= 0; o and o_multi hold; pend <= 0.
- When load is 0 (o_valid=1, o_ready=0):
  - o, o_valid and o_multi hold stable.
  - pend <= cand, so new requests accumulate.
- Latency: a request on i at edge t appears on o after edge t, provided the output register is free. Throughput is one grant per cycle.
- Level-held request: it is re-captured every cycle. With o_ready=1 the same index is re-granted whenever it is the top-priority candidate.
- en=0: i is ignored, but pending bits still drain through the handshake.
- All N bits set with o_ready=1: N consecutive grants in priority order, then o_valid drops.
- Non-power-of-two N: indices >= N are never produced.
- Reset mid-operation: all pending requests and any un-accepted output are discarded.
- The consumer must not rely on o when o_valid=0.

Optional Feature:
- Macro: PRIORITY_ENCODER_SYNC_RR_EN.
- Defined: round-robin priority.
  - A W-bit pointer ptr (reset 0) sets where the search starts: search from ptr upward, wrapping modulo N.
  - On each load with cand != 0, ptr <= (idx+1) mod N.
  - PRIO_LOW is ignored.
- Undefined: fixed priority per PRIO_LOW; no pointer register exists.

Decomposition:
- Package penc_pkg holds:
  - PENC_MAX_N = 256.
  - function penc_popcnt_gt1 (N-bit input, returns 1-bit).
- Sub-module penc_search: combinational N->W search.
  - Inputs: vector, start pointer, direction.
  - Outputs: idx, found.
  - Instantiated once; start pointer tied to 0 when RR is disabled.
- Top level holds the pend, o, o_valid, o_multi and ptr registers only.

Test Plan:
- N=8, PRIO_LOW=1, en=1, i=8'b0000_0100 for one cycle, o_ready=1 -> next cycle o=2, o_valid=1, o_multi=0; following cycle o_valid=0.
- i=8'b1001_0010 for one cycle, o_ready=1 -> o=1, 4, 7 on three consecutive cycles; o_multi=1, 1, 0; pend goes 0x90, 0x80, 0x00.
- i=8'b0000_0011 pulse, o_ready=0 for 3 cycles, i=8'b0100_0000 pulse during the stall -> o=0 held stable; on release o=1, then 6.
- en=0 with i=0xFF -> o_valid stays 0, pend stays 0. Then en=1 for one cycle -> 8 grants 0..7.
- PRIORITY_ENCODER_SYNC_RR_EN defined, i=0xFF held, o_ready=1 -> grants cycle 0,1,...,7,0 (pointer wraps).
- Assert rst_n=0 asynchronously mid-stall with o_valid=1 and pend=0x30 -> outputs clear immediately; after release, no stale grants.

Source files
------------

// File: rtl/penc_pkg.sv
// Shared constants and helpers for the synchronous priority encoder.
package penc_pkg;

    localparam int unsigned PENC_MAX_N = 256;

    // True when more than one bit of v is set (clearing the lowest set bit leaves something behind).
    function automatic logic penc_popcnt_gt1(input logic [PENC_MAX_N-1:0] v);
        return |(v & (v - PENC_MAX_N'(1)));
    endfunction

endpackage

// File: rtl/penc_search.sv
// Combinational N->W search: first set bit of i_vec, either starting at i_start and
// walking upward with wrap-around (i_dir_low=1) or walking down from N-1 (i_dir_low=0).
module penc_search #(
    parameter int unsigned N = 8,
    parameter int unsigned W = $clog2(N)
) (
    input  logic [N-1:0] i_vec,
    input  logic [W-1:0] i_start,
    input  logic         i_dir_low,
    output logic [W-1:0] o_idx,
    output logic         o_found
);

    // Scan from the lowest-priority position to the highest so the last hit wins.
    always_comb begin
        int pos;
        pos     = 0;
        o_idx   = '0;
        o_found = 1'b0;
        for (int k = int'(N) - 1; k >= 0; k--) begin
            if (i_dir_low) begin
                pos = int'(i_start) + k;
                if (pos >= int'(N)) begin
                    pos = pos - int'(N);
                end
            end else begin
                pos = int'(N) - 1 - k;
            end
            if (i_vec[W'(pos)]) begin
                o_idx   = W'(pos);
                o_found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/priority_encoder_sync.sv
// Registered priority encoder with sticky pending requests and a valid/ready output.
// Define PRIORITY_ENCODER_SYNC_RR_EN for round-robin arbitration (PRIO_LOW then ignored).
module priority_encoder_sync
    import penc_pkg::*;
#(
    parameter int unsigned N        = 8,
    parameter int unsigned PRIO_LOW = 1,
    localparam int unsigned W       = $clog2(N)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en,
    input  logic [N-1:0] i,
    input  logic         o_ready,
    output logic         o_valid,
    output logic [W-1:0] o,
    output logic         o_multi,
    output logic [N-1:0] pend
);

    logic [N-1:0] r_pend;
    logic [W-1:0] r_o;
    logic         r_valid;
    logic         r_multi;

    logic [N-1:0] w_cand;
    logic         w_load;
    logic [W-1:0] w_start;
    logic         w_dir_low;
    logic [W-1:0] w_idx;
    logic         w_found;
    logic         w_multi;
    logic [N-1:0] w_clr;

    assign w_cand  = r_pend | (en ? i : '0);
    assign w_load  = !r_valid || o_ready;
    assign w_multi = penc_popcnt_gt1(PENC_MAX_N'(w_cand));
    assign w_clr   = N'(1) << w_idx;

`ifdef PRIORITY_ENCODER_SYNC_RR_EN
    logic [W-1:0] r_ptr;

    assign w_start   = r_ptr;
    assign w_dir_low = 1'b1;

    // Round-robin pointer advances past every granted index.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr <= '0;
        end else if (w_load && w_found) begin
            r_ptr <= (w_idx == W'(N - 1)) ? '0 : w_idx + W'(1);
        end
    end
`else
    assign w_start   = '0;
    assign w_dir_low = (PRIO_LOW != 0);
`endif

    penc_search #(
        .N (N),
        .W (W)
    ) u_search (
        .i_vec     (w_cand),
        .i_start   (w_start),
        .i_dir_low (w_dir_low),
        .o_idx     (w_idx),
        .o_found   (w_found)
    );

    // Output register loads when empty or consumed; otherwise new requests accumulate in pend.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pend  <= '0;
            r_o     <= '0;
            r_valid <= 1'b0;
            r_multi <= 1'b0;
        end else if (w_load) begin
            if (w_found) begin
                r_o     <= w_idx;
                r_valid <= 1'b1;
                r_multi <= w_multi;
                r_pend  <= w_cand & ~w_clr;
            end else begin
                r_valid <= 1'b0;
                r_pend  <= '0;
            end
        end else begin
            r_pend <= w_cand;
        end
    end

    assign o_valid = r_valid;
    assign o       = r_o;
    assign o_multi = r_multi;
    assign pend    = r_pend;

endmodule
